// File: rtl/tone_sequencer.sv
// Queued tone(freq, duration) player: pops {period, dur} commands and drives the tone timer compare value.
// Optional inter-note silence is enabled with `define TONE_SEQ_GAP_EN (GAP state and GAP_MS parameter).
module tone_sequencer #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DUR_W      = 16
`ifdef TONE_SEQ_GAP_EN
    ,
    parameter int unsigned GAP_MS     = 10
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [31:0]      period_i,
    input  logic [DUR_W-1:0] dur_i,
    input  logic             stop_i,
    output logic [31:0]      tone_cp_o,
    output logic             busy_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             done_o,
    output logic             ovf_o
);

    localparam int unsigned PER_W   = 32;
    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [PER_W-1:0] period;
        logic [DUR_W-1:0] dur;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1
`ifdef TONE_SEQ_GAP_EN
        ,
        ST_GAP  = 2'd2
`endif
    } state_e;

    state_e             state_q, state_d;
    cmd_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUR_W-1:0]   rem_q, rem_d;
    logic [PER_W-1:0]   tone_cp_q, tone_cp_d;
    logic               busy_q, busy_d;
    logic               full_q, empty_q;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               wrap;
    cmd_t               head;
    cmd_t               wr_cmd;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = (state_q == ST_IDLE) && (count_q != '0) && !stop_i;
    assign push      = wr_en_i && !stop_i && (!fifo_full || pop);
    assign ovf_d     = wr_en_i && !stop_i && fifo_full && !pop;
    assign wrap      = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign head      = mem_q[rd_ptr_q];
    assign wr_cmd    = '{period: period_i, dur: dur_i};

    // Occupancy bookkeeping; stop flushes everything including a same-cycle write.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (stop_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (stop_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= wr_cmd;
                    wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
            empty_q <= (count_d == '0);
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (wrap && rem_q == DUR_W'(1)) begin
`ifdef TONE_SEQ_GAP_EN
                    state_d = (GAP_MS != 0) ? ST_GAP : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef TONE_SEQ_GAP_EN
            ST_GAP: begin
                if (wrap && rem_q == DUR_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (stop_i) begin
            state_d = ST_IDLE;
        end
    end

    // Prescaler/duration datapath and registered outputs; rem_q == 0 in PLAY means untimed.
    always_comb begin
        presc_d   = presc_q;
        rem_d     = rem_q;
        tone_cp_d = tone_cp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tone_cp_d = head.period;
                    rem_d     = head.dur;
                    presc_d   = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_PLAY: begin
                presc_d = wrap ? '0 : presc_q + PRESC_W'(1);
                if (wrap && rem_q != '0) begin
                    if (rem_q == DUR_W'(1)) begin
                        done_d    = 1'b1;
                        tone_cp_d = '0;
`ifdef TONE_SEQ_GAP_EN
                        if (GAP_MS != 0) begin
                            rem_d = DUR_W'(GAP_MS);
                        end else begin
                            rem_d  = '0;
                            busy_d = 1'b0;
                        end
`else
                        rem_d  = '0;
                        busy_d = 1'b0;
`endif
                    end else begin
                        rem_d = rem_q - DUR_W'(1);
                    end
                end
            end
`ifdef TONE_SEQ_GAP_EN
            ST_GAP: begin
                presc_d = wrap ? '0 : presc_q + PRESC_W'(1);
                if (wrap) begin
                    if (rem_q == DUR_W'(1)) begin
                        rem_d  = '0;
                        busy_d = 1'b0;
                    end else begin
                        rem_d = rem_q - DUR_W'(1);
                    end
                end
            end
`endif
            default: begin
                presc_d = '0;
            end
        endcase
        if (stop_i) begin
            presc_d   = '0;
            rem_d     = '0;
            tone_cp_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            presc_q   <= '0;
            rem_q     <= '0;
            tone_cp_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            rem_q     <= rem_d;
            tone_cp_q <= tone_cp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tone_cp_o = tone_cp_q;
    assign busy_o    = busy_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign done_o    = done_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICK_DIV=10, FIFO_DEPTH=4; inputs driven and outputs sampled on negedge.
module tb_tone_sequencer;

    localparam int unsigned TICK  = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 16;
`ifdef TONE_SEQ_GAP_EN
    localparam int   NEXT         = 21;
    localparam logic BUSY_AT_DONE = 1'b1;
`else
    localparam int   NEXT         = 1;
    localparam logic BUSY_AT_DONE = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          wr_en_i;
    logic [31:0]   period_i;
    logic [DW-1:0] dur_i;
    logic          stop_i;
    logic [31:0]   tone_cp_o;
    logic          busy_o, full_o, empty_o, done_o, ovf_o;

    int n_chk  = 0;
    int n_fail = 0;

    tone_sequencer #(
        .TICK_DIV  (TICK),
        .FIFO_DEPTH(DEPTH),
        .DUR_W     (DW)
`ifdef TONE_SEQ_GAP_EN
        ,
        .GAP_MS    (2)
`endif
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_en_i  (wr_en_i),
        .period_i (period_i),
        .dur_i    (dur_i),
        .stop_i   (stop_i),
        .tone_cp_o(tone_cp_o),
        .busy_o   (busy_o),
        .full_o   (full_o),
        .empty_o  (empty_o),
        .done_o   (done_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] p, input logic [DW-1:0] d);
        wr_en_i  = w;
        period_i = p;
        dur_i    = d;
    endtask

    // Count PLAY cycles up to the done pulse, checking the held value along the way.
    task automatic play_note(input string tag, input logic [31:0] p, input int cyc);
        int n   = 0;
        int bad = 0;
        while (done_o !== 1'b1 && n < 5000) begin
            if (tone_cp_o !== p || busy_o !== 1'b1) bad++;
            n++;
            @(negedge clk_i);
        end
        chk({tag, "_len"},  32'(n), 32'(cyc));
        chk({tag, "_hold"}, 32'(bad), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_off"},  tone_cp_o, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        rst_i  = 1'b0;
        stop_i = 1'b0;
        drive(1'b0, 32'd0, 16'd0);
        repeat (3) @(negedge clk_i);
        chk("rst_tone",  tone_cp_o, 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_full",  32'(full_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_done",  32'(done_o), 32'd0);
        chk("rst_ovf",   32'(ovf_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Single timed note: latency 2, exactly 30 cycles.
        drive(1'b1, 32'd1000, 16'd3);
        @(negedge clk_i);
        drive(1'b0, 32'd0, 16'd0);
        chk("t1_n1_tone",  tone_cp_o, 32'd0);
        chk("t1_n1_empty", 32'(empty_o), 32'd0);
        @(negedge clk_i);
        chk("t1_n2_tone", tone_cp_o, 32'd1000);
        play_note("t1", 32'd1000, 30);
        chk("t1_busy_fall", 32'(busy_o), 32'(BUSY_AT_DONE));
        @(negedge clk_i);
        chk("t1_done_pulse", 32'(done_o), 32'd0);
        repeat (NEXT + 2) @(negedge clk_i);
        chk("t1_idle_tone", tone_cp_o, 32'd0);

        // Three queued notes including a rest.
        drive(1'b1, 32'd1000, 16'd1);
        @(negedge clk_i);
        drive(1'b1, 32'd2000, 16'd2);
        @(negedge clk_i);
        drive(1'b1, 32'd0, 16'd1);
        @(negedge clk_i);
        drive(1'b0, 32'd0, 16'd0);
        play_note("t2a", 32'd1000, 9);
        repeat (NEXT) @(negedge clk_i);
        play_note("t2b", 32'd2000, 20);
        repeat (NEXT) @(negedge clk_i);
        play_note("t2c", 32'd0, 10);
        chk("t2_empty", 32'(empty_o), 32'd1);
        repeat (25) @(negedge clk_i);

        // Overfill while a 5 ms note plays.
        drive(1'b1, 32'd100, 16'd5);
        @(negedge clk_i);
        drive(1'b0, 32'd0, 16'd0);
        @(negedge clk_i);
        drive(1'b1, 32'd201, 16'd1);
        @(negedge clk_i);
        chk("t3_full_early", 32'(full_o), 32'd0);
        drive(1'b1, 32'd202, 16'd1);
        @(negedge clk_i);
        drive(1'b1, 32'd203, 16'd1);
        @(negedge clk_i);
        drive(1'b1, 32'd204, 16'd1);
        @(negedge clk_i);
        chk("t3_full", 32'(full_o), 32'd1);
        chk("t3_ovf_pre", 32'(ovf_o), 32'd0);
        drive(1'b1, 32'd205, 16'd1);
        @(negedge clk_i);
        drive(1'b0, 32'd0, 16'd0);
        chk("t3_ovf", 32'(ovf_o), 32'd1);
        chk("t3_full_hold", 32'(full_o), 32'd1);
        @(negedge clk_i);
        chk("t3_ovf_pulse", 32'(ovf_o), 32'd0);
        play_note("t3_n0", 32'd100, 44);
        repeat (NEXT) @(negedge clk_i);
        play_note("t3_n1", 32'd201, 10);
        repeat (NEXT) @(negedge clk_i);
        play_note("t3_n2", 32'd202, 10);
        repeat (NEXT) @(negedge clk_i);
        play_note("t3_n3", 32'd203, 10);
        repeat (NEXT) @(negedge clk_i);
        play_note("t3_n4", 32'd204, 10);
        repeat (25) @(negedge clk_i);
        chk("t3_end_empty", 32'(empty_o), 32'd1);
        chk("t3_end_busy",  32'(busy_o), 32'd0);
        chk("t3_end_tone",  tone_cp_o, 32'd0);

        // Untimed note runs until stop, which also flushes the queue.
        drive(1'b1, 32'd500, 16'd0);
        @(negedge clk_i);
        drive(1'b0, 32'd0, 16'd0);
        @(negedge clk_i);
        drive(1'b1, 32'd600, 16'd3);
        @(negedge clk_i);
        drive(1'b0, 32'd0, 16'd0);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (tone_cp_o !== 32'd500 || done_o !== 1'b0) bad++;
            @(negedge clk_i);
        end
        chk("t4_hold", 32'(bad), 32'd0);
        chk("t4_queued", 32'(empty_o), 32'd0);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        chk("t4_stop_tone",  tone_cp_o, 32'd0);
        chk("t4_stop_empty", 32'(empty_o), 32'd1);
        chk("t4_stop_busy",  32'(busy_o), 32'd0);
        chk("t4_stop_done",  32'(done_o), 32'd0);
        repeat (5) @(negedge clk_i);
        chk("t4_flushed", tone_cp_o, 32'd0);

        // stop and write in the same cycle with two entries queued.
        drive(1'b1, 32'd700, 16'd0);
        @(negedge clk_i);
        drive(1'b0, 32'd0, 16'd0);
        @(negedge clk_i);
        drive(1'b1, 32'd701, 16'd1);
        @(negedge clk_i);
        drive(1'b1, 32'd702, 16'd1);
        @(negedge clk_i);
        chk("t5_two_queued", 32'(empty_o), 32'd0);
        drive(1'b1, 32'd703, 16'd1);
        stop_i = 1'b1;
        @(negedge clk_i);
        drive(1'b0, 32'd0, 16'd0);
        stop_i = 1'b0;
        chk("t5_empty", 32'(empty_o), 32'd1);
        chk("t5_ovf",   32'(ovf_o), 32'd0);
        chk("t5_tone",  tone_cp_o, 32'd0);
        repeat (15) @(negedge clk_i);
        chk("t5_lost_tone", tone_cp_o, 32'd0);
        chk("t5_lost_busy", 32'(busy_o), 32'd0);

        // Asynchronous reset in the middle of a note.
        drive(1'b1, 32'd900, 16'd3);
        @(negedge clk_i);
        drive(1'b0, 32'd0, 16'd0);
        @(negedge clk_i);
        repeat (14) @(negedge clk_i);
        chk("t6_mid_tone", tone_cp_o, 32'd900);
        #2;
        rst_i = 1'b0;
        #1;
        chk("t6_async_tone",  tone_cp_o, 32'd0);
        chk("t6_async_empty", 32'(empty_o), 32'd1);
        chk("t6_async_busy",  32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("t6_post_tone", tone_cp_o, 32'd0);
        chk("t6_post_busy", 32'(busy_o), 32'd0);
        chk("t6_post_done", 32'(done_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
